instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage of the IITB RISC pipeline; the producing end of the 16-bit instruction interface that the decode stage consumes.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents them, with their PC, to decode.
- Supports stall from decode and flush/redirect from branch resolution.

Parameters:
- DEPTH, 2, prefetch FIFO entries; power of 2, minimum 2.
- RESET_PC, 16'h0000, PC value loaded at reset.

Ports:
- clk  in  1  clock; all state updates on posedge
- resetn  in  1  reset, synchronous, active-low
- stall  in  1  decode not ready; head entry is held
- flush  in  1  discard all buffered and in-flight fetches, restart at redirect_pc
- redirect_pc  in  16  new fetch address; sampled when flush=1
- imem_req  out  1  registered memory read request
- imem_addr  out  16  registered word address; stable while imem_req=1 and no ack
- imem_ack  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- instr_valid  out  1  FIFO head valid
- instr  out  16  FIFO head instruction; 16'h0000 when instr_valid=0
- instr_pc  out  16  PC of head instruction; 16'h0000 when instr_valid=0
- fetch_cnt  out  16  delivered-instruction count (see Optional Feature)

Behaviour:
- Reset (resetn=0 at posedge):
  - pc=RESET_PC; FIFO empty; state=IDLE.
  - imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, fetch_cnt=0.
- Pop: occurs when instr_valid=1 and stall=0 and flush=0. The head advances at that posedge.
- Push: {imem_rdata, imem_addr} is written at the tail on imem_ack in state WAIT, unless flush=1.
- At most one request is outstanding at any time.
- States:
  - IDLE: if flush, pc=redirect_pc and stay IDLE. Else if count<DEPTH, set imem_req=1 and imem_addr=pc, pc=pc+1, go to WAIT.
  - WAIT: imem_req=1, address held.
    - On ack with flush: data dropped; imem_req=0; pc=redirect_pc; go to IDLE.
    - On ack without flush: push. If (count+1-pop)<DEPTH, re-issue back-to-back at imem_addr=pc, pc=pc+1, and stay in WAIT. Otherwise imem_req=0 and go to IDLE.
    - On flush without ack: pc=redirect_pc; go to DROP (request stays asserted, address unchanged, to honour the protocol).
  - DROP: on ack, discard data, imem_req=0, go to IDLE. A further flush in DROP only updates pc=redirect_pc.
- Flush always empties the FIFO in the same posedge; instr_valid=0 the following cycle.
- Flush has priority over pop and push in the same cycle.
- Push and pop in the same cycle: count unchanged, data order preserved.
- Push never occurs when full, because issue requires space.
- Throughput: 1 instruction/cycle with single-cycle ack. Latency from flush to the first instr_valid=1 is 3 cycles with immediate ack (flush → req → ack → valid).
- pc and imem_addr wrap 16'hFFFF → 16'h0000.
- Outputs instr, instr_pc, instr_valid are driven from registers (FIFO head). No combinational path from imem_rdata to instr.
- instr is held stable while stall=1.

Optional Feature:
- Macro: IF_FETCH_CNT_EN.
- Defined: fetch_cnt increments by 1 on every pop and wraps at 16'hFFFF→0. It clears on reset and is not cleared by flush.
- Undefined: fetch_cnt tied to 16'h0000; no counter logic.

Test Plan:
- Reset, then release with ack returned the cycle after each req, stall=0, memory[n]=16'h1000+n → instr sequence 16'h1000,1001,1002… with instr_pc 0,1,2…, one per cycle after the first arrives.
- stall=1 for 4 cycles with DEPTH=2 → at most 2 entries buffered; imem_req deasserts; instr holds its value. Release → no instruction lost or duplicated.
- flush with redirect_pc=16'h0040 while in WAIT, ack 3 cycles later → returned word discarded. Next imem_addr=16'h0040; first delivered instr_pc=16'h0040.
- flush and imem_ack in the same cycle → data dropped, FIFO empty next cycle, next request at redirect_pc.
- RESET_PC=16'hFFFE, no stall → fetch addresses FFFE, FFFF, 0000, 0001.
- With IF_FETCH_CNT_EN: 10 pops, then flush, then 3 pops → fetch_cnt=13. Without the macro → fetch_cnt stays 0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Purpose: fetch-stage bundle (decode-side control, imem req/ack bus, decode-facing instruction head).
// Latency: none; wires only.
// Backpressure: n/a; the stall and imem_ack fields carry flow control between the parties.
//
// Ports (by modport):
//   master (fetch unit) : in  stall, flush, redirect_pc, imem_ack, imem_rdata
//                         out imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_cnt
//   slave  (environment): the mirror image of master
interface instr_fetch_unit_if;
   // decode / branch-resolution control
   logic        stall;
   logic        flush;
   logic [15:0] redirect_pc;
   // instruction memory read bus
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   // FIFO head presented to decode
   logic        instr_valid;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic [15:0] fetch_cnt;

   modport master (
      input  stall, flush, redirect_pc, imem_ack, imem_rdata,
      output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_cnt
   );

   modport slave (
      output stall, flush, redirect_pc, imem_ack, imem_rdata,
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_cnt
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose: IITB RISC fetch stage; holds the PC, issues single-outstanding imem reads, buffers words for decode.
// Latency: 1 instr/cycle with single-cycle ack; flush to first instr_valid is 3 cycles (flush, req, ack).
// Backpressure: stall holds the FIFO head; no new read is issued unless its word is guaranteed a FIFO slot.
//
// Ports:
//   clk     - clock, all state on posedge
//   resetn  - synchronous active-low reset
//   bus     - instr_fetch_unit_if.master: stall/flush/redirect_pc from the pipeline,
//             imem_req/imem_addr/imem_ack/imem_rdata to instruction memory,
//             instr_valid/instr/instr_pc/fetch_cnt towards decode
// Parameters: DEPTH (prefetch entries, power of 2, >= 2), RESET_PC (PC after reset).
// Optional feature: define IF_FETCH_CNT_EN to build the delivered-instruction counter on fetch_cnt;
// otherwise fetch_cnt is tied to zero.
module instr_fetch_unit #(
   parameter int          DEPTH    = 2,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic               clk,
   input  logic               resetn,
   instr_fetch_unit_if.master bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   // Request engine states
   localparam logic [1:0] ST_IDLE = 2'd0;   // no request outstanding
   localparam logic [1:0] ST_WAIT = 2'd1;   // live request outstanding, its data will be kept
   localparam logic [1:0] ST_DROP = 2'd2;   // request outstanding but flushed, its data will be discarded

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } entry_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]    state_q, state_d;
   logic [15:0]   pc_q, pc_d;
   logic          req_q, req_d;
   logic [15:0]   addr_q, addr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   entry_t        fifo_q [DEPTH];

   // ------------------------------------------------------------------
   // FIFO events
   // ------------------------------------------------------------------
   logic          head_vld;
   logic          pop;
   logic          push;
   logic [CW:0]   occ_after;
   logic          reissue_ok;
   entry_t        head;

   assign head_vld = (count_q != '0);

   // Flush outranks both ends of the FIFO: a flushed cycle neither consumes
   // the head nor keeps the returning word.
   assign pop  = head_vld && !bus.stall && !bus.flush;
   assign push = (state_q == ST_WAIT) && bus.imem_ack && !bus.flush;

   // Occupancy once this cycle's push and pop land. A back-to-back request is
   // only issued if its word will certainly have a slot, so a push can never
   // hit a full FIFO.
   assign occ_after  = {1'b0, count_q} + {{CW{1'b0}}, 1'b1} - {{CW{1'b0}}, pop};
   assign reissue_ok = (occ_after < {1'b0, DEPTH_C});

   // ------------------------------------------------------------------
   // Request engine
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      addr_d  = addr_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.flush) begin
               pc_d = bus.redirect_pc;
            end else if (count_q < DEPTH_C) begin
               req_d   = 1'b1;
               addr_d  = pc_q;
               pc_d    = pc_q + 16'd1;
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (bus.imem_ack) begin
               if (bus.flush) begin
                  req_d   = 1'b0;
                  pc_d    = bus.redirect_pc;
                  state_d = ST_IDLE;
               end else if (reissue_ok) begin
                  // keep req high and move straight on to the next word
                  addr_d = pc_q;
                  pc_d   = pc_q + 16'd1;
               end else begin
                  req_d   = 1'b0;
                  state_d = ST_IDLE;
               end
            end else if (bus.flush) begin
               // The memory still owes us a response: leave req/addr untouched
               // and swallow the data when it arrives.
               pc_d    = bus.redirect_pc;
               state_d = ST_DROP;
            end
         end

         ST_DROP: begin
            if (bus.flush) begin
               pc_d = bus.redirect_pc;
            end
            if (bus.imem_ack) begin
               req_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FIFO pointers and occupancy
   // ------------------------------------------------------------------
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (bus.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         req_q    <= 1'b0;
         addr_q   <= 16'h0000;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only visible once count covers it.
   always_ff @(posedge clk) begin
      if (resetn && push) begin
         fifo_q[wr_ptr_q] <= '{instr: bus.imem_rdata, pc: addr_q};
      end
   end

   // ------------------------------------------------------------------
   // Outputs: all taken from registers, never from imem_rdata
   // ------------------------------------------------------------------
   assign head = fifo_q[rd_ptr_q];

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = addr_q;
   assign bus.instr_valid = head_vld;
   assign bus.instr       = head_vld ? head.instr : 16'h0000;
   assign bus.instr_pc    = head_vld ? head.pc    : 16'h0000;

`ifdef IF_FETCH_CNT_EN
   // Counts instructions handed to decode; survives flush, cleared only by reset.
   logic [15:0] fcnt_q, fcnt_d;

   always_comb begin
      fcnt_d = fcnt_q;
      if (pop) begin
         fcnt_d = fcnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         fcnt_q <= 16'h0000;
      end else begin
         fcnt_q <= fcnt_d;
      end
   end

   assign bus.fetch_cnt = fcnt_q;
`else
   assign bus.fetch_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose: self-checking bench for instr_fetch_unit (directed scenarios plus random stall/flush/latency).
// Latency: n/a.
// Backpressure: n/a; the bench plays both decode and instruction memory.
module tb_instr_fetch_unit;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus ();
   instr_fetch_unit_if bus2 ();

   instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_wrap (
      .clk(clk), .resetn(resetn), .bus(bus2)
   );

   int tests = 0;
   int fails = 0;

   // memory image: word at address a is 16'h1000 + a
   function automatic logic [15:0] memw(input logic [15:0] a);
      return 16'h1000 + a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Instruction memory responder: ack after cur_lat idle cycles
   // ------------------------------------------------------------------
   int lat_lo = 0;
   int lat_hi = 0;
   int cur_lat = 0;
   int wait_cnt = 0;

   initial begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 16'h0000;
      forever begin
         @(posedge clk);
         #1;
         if (resetn && bus.imem_req) begin
            if (wait_cnt >= cur_lat) begin
               bus.imem_ack = 1'b1;
               wait_cnt     = 0;
               cur_lat      = int'($urandom_range(lat_hi, lat_lo));
            end else begin
               bus.imem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            bus.imem_ack = 1'b0;
            wait_cnt     = 0;
         end
         bus.imem_rdata = bus.imem_ack ? memw(bus.imem_addr) : 16'($urandom);
      end
   end

   // Second instance: immediate ack, no stall, used for the PC-wrap case
   logic [15:0] a2 [4];
   int n2 = 0;

   initial begin
      bus2.stall       = 1'b0;
      bus2.flush       = 1'b0;
      bus2.redirect_pc = 16'h0000;
      bus2.imem_ack    = 1'b0;
      bus2.imem_rdata  = 16'h0000;
      forever begin
         @(posedge clk);
         #1;
         bus2.imem_ack   = resetn && bus2.imem_req;
         bus2.imem_rdata = memw(bus2.imem_addr);
      end
   end

   always @(negedge clk) begin
      if (resetn && bus2.imem_req && n2 < 4) begin
         a2[n2] = bus2.imem_addr;
         n2++;
      end
   end

   // ------------------------------------------------------------------
   // Behavioural model + compare (every negedge)
   //   m_count   : words held for decode
   //   m_deliver : PC of the oldest undelivered word (stream is sequential)
   //   m_issue   : next address a fresh request must use
   //   m_live    : outstanding request's data will be kept
   // ------------------------------------------------------------------
   logic        m_on = 1'b0;
   int          m_count = 0;
   logic [15:0] m_deliver, m_issue, m_addr, m_fcnt;
   logic        m_req, m_live, m_new;
   logic        p_pop, p_push, p_nr;

   initial begin
      forever begin
         @(negedge clk);
         if (m_on) begin
            chk("instr_valid", bus.instr_valid, m_count != 0);
            if (m_count != 0) begin
               chk("instr_pc", bus.instr_pc, m_deliver);
               chk("instr", bus.instr, memw(m_deliver));
            end else begin
               chk("instr_when_empty", bus.instr, 32'h0);
               chk("instr_pc_when_empty", bus.instr_pc, 32'h0);
            end
            chk("fetch_cnt", bus.fetch_cnt, m_fcnt);
            chk("imem_req", bus.imem_req, m_req);
            if (m_req) begin
               if (m_new) chk("imem_addr_issue", bus.imem_addr, m_addr);
               else       chk("imem_addr_hold", bus.imem_addr, m_addr);
            end
         end

         if (!resetn) begin
            m_on      = 1'b1;
            m_count   = 0;
            m_deliver = 16'h0000;
            m_issue   = 16'h0000;
            m_addr    = 16'h0000;
            m_fcnt    = 16'h0000;
            m_req     = 1'b0;
            m_live    = 1'b0;
            m_new     = 1'b0;
         end else if (m_on) begin
            p_pop  = (m_count != 0) && !bus.stall && !bus.flush;
            p_push = m_req && bus.imem_ack && m_live && !bus.flush;
            if (!m_req)                    p_nr = !bus.flush && (m_count < DEPTH);
            else if (!bus.imem_ack)        p_nr = 1'b1;
            else if (!m_live || bus.flush) p_nr = 1'b0;
            else                           p_nr = (m_count + 1 - int'(p_pop)) < DEPTH;

            if (bus.flush) begin
               m_count   = 0;
               m_deliver = bus.redirect_pc;
               m_issue   = bus.redirect_pc;
               m_live    = 1'b0;
            end else begin
               m_count = m_count + int'(p_push) - int'(p_pop);
               if (p_pop) m_deliver = m_deliver + 16'd1;
            end
`ifdef IF_FETCH_CNT_EN
            if (p_pop) m_fcnt = m_fcnt + 16'd1;
`endif
            m_new = p_nr && (!m_req || bus.imem_ack);
            if (m_new) begin
               m_addr  = m_issue;
               m_issue = m_issue + 16'd1;
               m_live  = 1'b1;
            end
            m_req = p_nr;
         end
      end
   end

   // ------------------------------------------------------------------
   // Directed helpers (inputs change at posedge + 2)
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!bus.instr_valid && n < 30) begin
         step();
         n++;
      end
      chk(name, bus.instr_valid, 32'h1);
   endtask

   task automatic wait_req(input logic lvl, input string name);
      int n = 0;
      while (bus.imem_req !== lvl && n < 30) begin
         step();
         n++;
      end
      chk(name, bus.imem_req, lvl);
   endtask

   task automatic count_pops(input int target, input string name);
      int pops = 0;
      int guard = 0;
      while (pops < target && guard < 200) begin
         if (bus.instr_valid && !bus.stall && !bus.flush) pops++;
         step();
         guard++;
      end
      chk(name, pops, target);
   endtask

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   logic [15:0] saved;

   initial begin
      bus.stall       = 1'b0;
      bus.flush       = 1'b0;
      bus.redirect_pc = 16'h0000;
      resetn          = 1'b0;
      repeat (3) @(posedge clk);
      #2;

      // reset values
      chk("rst_imem_req", bus.imem_req, 32'h0);
      chk("rst_imem_addr", bus.imem_addr, 32'h0);
      chk("rst_instr_valid", bus.instr_valid, 32'h0);
      chk("rst_instr", bus.instr, 32'h0);
      chk("rst_instr_pc", bus.instr_pc, 32'h0);
      chk("rst_fetch_cnt", bus.fetch_cnt, 32'h0);
      resetn = 1'b1;

      // streaming with single-cycle ack: one instruction per cycle
      wait_valid("p1_first_valid");
      for (int k = 0; k < 6; k++) begin
         chk("p1_valid", bus.instr_valid, 32'h1);
         chk("p1_instr", bus.instr, 32'h1000 + k);
         chk("p1_pc", bus.instr_pc, k);
         step();
      end

      // wrap instance: FFFE, FFFF, 0000, 0001
      chk("wrap_nreq", n2, 4);
      chk("wrap_addr0", a2[0], 32'hFFFE);
      chk("wrap_addr1", a2[1], 32'hFFFF);
      chk("wrap_addr2", a2[2], 32'h0000);
      chk("wrap_addr3", a2[3], 32'h0001);

      // stall 4 cycles: head held, request stops once FIFO would fill
      saved     = bus.instr;
      bus.stall = 1'b1;
      repeat (4) begin
         step();
         chk("p2_hold_instr", bus.instr, saved);
      end
      chk("p2_req_off", bus.imem_req, 32'h0);
      chk("p2_valid", bus.instr_valid, 32'h1);
      bus.stall = 1'b0;

      // flush while waiting on a 3-cycle memory
      lat_lo = 3;
      lat_hi = 3;
      repeat (12) step();
      begin
         int n = 0;
         while (!(bus.imem_req && !bus.imem_ack) && n < 30) begin
            step();
            n++;
         end
      end
      chk("p3_in_wait", bus.imem_req && !bus.imem_ack, 32'h1);
      bus.flush       = 1'b1;
      bus.redirect_pc = 16'h0040;
      step();
      bus.flush = 1'b0;
      wait_req(1'b0, "p3_drop_done");
      wait_req(1'b1, "p3_new_req");
      chk("p3_addr", bus.imem_addr, 32'h0040);
      wait_valid("p3_first_valid");
      chk("p3_first_pc", bus.instr_pc, 32'h0040);
      chk("p3_first_instr", bus.instr, 32'h1040);

      // flush in the same cycle as ack
      lat_lo = 0;
      lat_hi = 0;
      repeat (8) step();
      begin
         int n = 0;
         while (!bus.imem_ack && n < 30) begin
            step();
            n++;
         end
      end
      chk("p4_ack_seen", bus.imem_ack, 32'h1);
      bus.flush       = 1'b1;
      bus.redirect_pc = 16'h0100;
      step();
      bus.flush = 1'b0;
      chk("p4_empty", bus.instr_valid, 32'h0);
      chk("p4_req_off", bus.imem_req, 32'h0);
      wait_req(1'b1, "p4_new_req");
      chk("p4_addr", bus.imem_addr, 32'h0100);

      // delivered-instruction counter: 10 pops, flush, 3 pops
      resetn = 1'b0;
      repeat (2) step();
      resetn = 1'b1;
      count_pops(10, "p5_pops_a");
      bus.flush       = 1'b1;
      bus.redirect_pc = 16'h0200;
      step();
      bus.flush = 1'b0;
      count_pops(3, "p5_pops_b");
`ifdef IF_FETCH_CNT_EN
      chk("p5_fetch_cnt", bus.fetch_cnt, 32'd13);
`else
      chk("p5_fetch_cnt", bus.fetch_cnt, 32'd0);
`endif

      // random stall / flush / memory latency
      lat_lo = 0;
      lat_hi = 3;
      for (int c = 0; c < 3000; c++) begin
         if (c % 600 == 300) lat_hi = 0;
         if (c % 600 == 0)   lat_hi = 3;
         bus.stall = ($urandom_range(0, 99) < 30);
         bus.flush = ($urandom_range(0, 99) < 4);
         if ($urandom_range(0, 3) == 0)
            bus.redirect_pc = 16'hFFFC + 16'($urandom_range(0, 3));
         else
            bus.redirect_pc = 16'($urandom);
         step();
      end
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      repeat (20) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
